// File: rtl/framing_pkg.sv
// rtl/framing_pkg.sv - byte framing protocol constants and deframer state type
package framing_pkg;
  localparam logic [7:0] DEFAULT_ESCAPE_BYTE = 8'h7F;
  localparam logic [7:0] DEFAULT_START_BYTE  = 8'h7D;
  localparam logic [7:0] DEFAULT_STOP_BYTE   = 8'h7E;

  typedef enum logic [1:0] {HUNT, DATA, ESC} deframe_state_t;
endpackage

// File: rtl/rx_frame_decoder.sv
// rtl/rx_frame_decoder.sv - raw byte stream to AXI-Stream payload frames with error reporting
module rx_frame_decoder
  import framing_pkg::*;
#(
  parameter logic [7:0]  ESCAPE_BYTE = DEFAULT_ESCAPE_BYTE,
  parameter logic [7:0]  START_BYTE  = DEFAULT_START_BYTE,
  parameter logic [7:0]  STOP_BYTE   = DEFAULT_STOP_BYTE,
  parameter int unsigned MAX_LEN     = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        rxbyte_tvalid,
  output logic        rxbyte_tready,
  input  logic [7:0]  rxbyte_tdata,
  output logic        rxframe_tvalid,
  input  logic        rxframe_tready,
  output logic [7:0]  rxframe_tdata,
  output logic        rxframe_tlast,
  output logic        rxframe_tuser,
  output logic [15:0] err_count,
  output logic        in_frame
);

  localparam logic [15:0] LEN_LIMIT = 16'(MAX_LEN);

  deframe_state_t state, state_n;
  logic [7:0]  hold_data, hold_data_n;
  logic        hold_full, hold_full_n;
  logic [15:0] len, len_n;
  logic        accept;
  logic        emit, emit_last, emit_user, err_inc;
  logic        do_payload, do_abort, do_stop, is_special;

  assign rxbyte_tready = !rxframe_tvalid || rxframe_tready;
  assign accept        = rxbyte_tvalid && rxbyte_tready;
  assign is_special    = (rxbyte_tdata == START_BYTE) || (rxbyte_tdata == STOP_BYTE) ||
                         (rxbyte_tdata == ESCAPE_BYTE);

  // Decode what the byte on rxbyte_tdata would do if accepted this cycle.
  always_comb begin
    state_n     = state;
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    len_n       = len;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_user   = 1'b0;
    err_inc     = 1'b0;
    do_payload  = 1'b0;
    do_abort    = 1'b0;
    do_stop     = 1'b0;

    case (state)
      HUNT: begin
        if (rxbyte_tdata == START_BYTE) begin
          state_n = DATA;
          len_n   = '0;
        end
      end
      DATA: begin
        if (rxbyte_tdata == START_BYTE) begin
          do_abort = 1'b1;
          state_n  = DATA;
          len_n    = '0;
        end else if (rxbyte_tdata == STOP_BYTE) begin
          do_stop = 1'b1;
          state_n = HUNT;
        end else if (rxbyte_tdata == ESCAPE_BYTE) begin
          state_n = ESC;
        end else begin
          do_payload = 1'b1;
        end
      end
      ESC: begin
        if (is_special) begin
          do_payload = 1'b1;
          state_n    = DATA;
        end else begin
          do_abort = 1'b1;
          state_n  = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase

    // An over-length byte turns into an abort and is itself dropped.
    if (do_payload) begin
      if (len == LEN_LIMIT) begin
        do_abort = 1'b1;
        state_n  = HUNT;
      end else begin
        emit        = hold_full;
        hold_data_n = rxbyte_tdata;
        hold_full_n = 1'b1;
        len_n       = len + 16'd1;
      end
    end

    if (do_abort) begin
      emit        = hold_full;
      emit_last   = 1'b1;
      emit_user   = 1'b1;
      hold_full_n = 1'b0;
      err_inc     = 1'b1;
    end

    if (do_stop) begin
      emit        = hold_full;
      emit_last   = 1'b1;
      hold_full_n = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= HUNT;
      hold_data      <= '0;
      hold_full      <= 1'b0;
      len            <= '0;
      in_frame       <= 1'b0;
      err_count      <= '0;
      rxframe_tvalid <= 1'b0;
      rxframe_tdata  <= '0;
      rxframe_tlast  <= 1'b0;
      rxframe_tuser  <= 1'b0;
    end else begin
      if (accept) begin
        state     <= state_n;
        hold_data <= hold_data_n;
        hold_full <= hold_full_n;
        len       <= len_n;
        in_frame  <= (state_n != HUNT);
        if (err_inc && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end
      // accept implies the output slot is empty or draining this edge.
      if (accept && emit) begin
        rxframe_tvalid <= 1'b1;
        rxframe_tdata  <= hold_data;
        rxframe_tlast  <= emit_last;
        rxframe_tuser  <= emit_user;
      end else if (rxframe_tready) begin
        rxframe_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb/tb_rx_frame_decoder.sv - randomized scoreboard bench for rx_frame_decoder
module tb_rx_frame_decoder;

  localparam int TB_MAX_LEN = 4;
  localparam logic [7:0] ST = 8'h7D;
  localparam logic [7:0] SP = 8'h7E;
  localparam logic [7:0] ES = 8'h7F;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        rxbyte_tvalid = 1'b0;
  logic        rxbyte_tready;
  logic [7:0]  rxbyte_tdata = 8'h00;
  logic        rxframe_tvalid;
  logic        rxframe_tready = 1'b1;
  logic [7:0]  rxframe_tdata;
  logic        rxframe_tlast;
  logic        rxframe_tuser;
  logic [15:0] err_count;
  logic        in_frame;

  beat_t      exp_q[$];
  beat_t      act_q[$];
  logic [7:0] cur[$];
  logic [7:0] seq[$];
  int         m_mode = 0;   // 0 hunting, 1 in frame, 2 after escape
  int         m_err = 0;
  int         tests = 0;
  int         fails = 0;
  int         tr_mode = 0;  // 0 always ready, 1 random, 2 toggling

  rx_frame_decoder #(.MAX_LEN(TB_MAX_LEN)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .rxbyte_tvalid  (rxbyte_tvalid),
    .rxbyte_tready  (rxbyte_tready),
    .rxbyte_tdata   (rxbyte_tdata),
    .rxframe_tvalid (rxframe_tvalid),
    .rxframe_tready (rxframe_tready),
    .rxframe_tdata  (rxframe_tdata),
    .rxframe_tlast  (rxframe_tlast),
    .rxframe_tuser  (rxframe_tuser),
    .err_count      (err_count),
    .in_frame       (in_frame)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is collected whole, then released as beats.
  task automatic release_frame(input bit aborted);
    for (int i = 0; i < cur.size(); i++) begin
      beat_t b;
      b.d = cur[i];
      b.l = (i == cur.size() - 1);
      b.u = aborted && (i == cur.size() - 1);
      exp_q.push_back(b);
    end
    cur.delete();
  endtask

  task automatic model_abort();
    release_frame(1'b1);
    m_err++;
  endtask

  task automatic model_add(input logic [7:0] b);
    if (cur.size() == TB_MAX_LEN) begin
      model_abort();
      m_mode = 0;
    end else begin
      cur.push_back(b);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_mode)
      0: if (b == ST) m_mode = 1;
      1: begin
        if (b == ST) model_abort();
        else if (b == SP) begin release_frame(1'b0); m_mode = 0; end
        else if (b == ES) m_mode = 2;
        else model_add(b);
      end
      default: begin
        if (b == ST || b == SP || b == ES) begin m_mode = 1; model_add(b); end
        else begin model_abort(); m_mode = 0; end
      end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        0: rxframe_tready = 1'b1;
        1: rxframe_tready = 1'($urandom % 2);
        default: rxframe_tready = ~rxframe_tready;
      endcase
    end
  end

  // Monitor: captures handshaked beats and checks AXI stability and ready.
  initial begin
    beat_t prev, a, e;
    bit prev_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        check("rxbyte_tready", 32'(rxbyte_tready), 32'(!rxframe_tvalid || rxframe_tready));
        a = {rxframe_tdata, rxframe_tlast, rxframe_tuser};
        if (prev_stall) begin
          check("stall_valid", 32'(rxframe_tvalid), 32'd1);
          check("stall_beat", 32'(a), 32'(prev));
        end
        if (rxframe_tvalid && rxframe_tready) act_q.push_back(a);
        prev_stall = rxframe_tvalid && !rxframe_tready;
        prev = a;
      end
      while (act_q.size() > 0 && exp_q.size() > 0) begin
        a = act_q.pop_front();
        e = exp_q.pop_front();
        check("beat", 32'(a), 32'(e));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rxbyte_tvalid = 1'b1;
    rxbyte_tdata  = b;
    do begin
      @(negedge aclk);
      n++;
    end while (!rxbyte_tready && n < 500);
    if (!rxbyte_tready) begin
      check("accept_timeout", 32'd0, 32'd1);
      rxbyte_tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    model_byte(b);
    rxbyte_tvalid = 1'b0;
    check("in_frame", 32'(in_frame), 32'(m_mode != 0));
    check("err_count", 32'(err_count), 32'(m_err));
    if ($urandom % 4 == 0) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic do_reset();
    tr_mode = 0;
    rxbyte_tvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b1;
    // Every byte but the newest has already left through the output stage.
    for (int i = 0; i + 1 < cur.size(); i++) begin
      beat_t b;
      b.d = cur[i];
      b.l = 1'b0;
      b.u = 1'b0;
      exp_q.push_back(b);
    end
    cur.delete();
    m_mode = 0;
    m_err = 0;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_tvalid", 32'(rxframe_tvalid), 32'd0);
    check("rst_tdata", 32'(rxframe_tdata), 32'd0);
    check("rst_tlast_tuser", 32'({rxframe_tlast, rxframe_tuser}), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_frame", 32'(in_frame), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int len, err, n;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_tvalid", 32'(rxframe_tvalid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_frame", 32'(in_frame), 32'd0);
    check("rst_rxbyte_tready", 32'(rxbyte_tready), 32'd1);

    tr_mode = 0;
    seq = '{ST, 8'h01, 8'h02, 8'h03, SP};
    send_seq(seq);
    tr_mode = 2;
    seq = '{ST, ES, ST, ES, ES, ES, SP, SP};
    send_seq(seq);
    tr_mode = 1;
    seq = '{ST, 8'hAA, ES, 8'h41, 8'hBB, SP};
    send_seq(seq);
    seq = '{ST, 8'h11, ST, 8'h22, SP, ST, SP};
    send_seq(seq);
    tr_mode = 0;
    seq = '{ST, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, SP, ST, 8'h09, SP};
    send_seq(seq);
    seq = '{ST, 8'h01, 8'h02};
    send_seq(seq);
    do_reset();
    seq = '{ST, 8'h05, SP};
    send_seq(seq);

    for (int f = 0; f < 60; f++) begin
      tr_mode = int'($urandom % 3);
      if ($urandom % 4 == 0) send_byte(8'($urandom));
      send_byte(ST);
      len = int'($urandom_range(0, 6));
      err = int'($urandom % 10);
      for (int i = 0; i < len; i++) begin
        if (i == 0 && err == 0) begin send_byte(ES); send_byte(8'h41); end
        if (i == 0 && err == 1) send_byte(ST);
        case ($urandom % 8)
          0: b = ST;
          1: b = SP;
          2: b = ES;
          default: b = 8'($urandom);
        endcase
        if (b == ST || b == SP || b == ES) send_byte(ES);
        send_byte(b);
      end
      send_byte(SP);
    end

    // Close whatever state the stream is in so every frame is released.
    send_byte(ST);
    send_byte(SP);
    tr_mode = 0;
    n = 0;
    while ((exp_q.size() != 0 || act_q.size() != 0) && n < 200) begin
      @(posedge aclk);
      n++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    check("final_act_empty", 32'(act_q.size()), 32'd0);
    check("final_err_count", 32'(err_count), 32'(m_err));
    check("final_in_frame", 32'(in_frame), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_frame_decoder.md
Name: rx_frame_decoder

Overview:
Single-block receive-side decoder for the byte framing protocol: the inverse of the transmit escaper+framer chain. Takes the raw byte stream from the UART/byte link, hunts for START, strips ESCAPE prefixes, ends the frame on STOP and emits the payload as an AXI4-Stream frame with tlast on the final payload byte. Adds error detection and reporting: bad escape, START inside a frame, and over-length frames. Sits between the byte receiver and the frame consumer, replacing the two-stage deframe/de-escape path where error reporting is needed.

Parameters:
ESCAPE_BYTE, 8'h7F, escape marker; the following byte is taken literally.
START_BYTE, 8'h7D, frame start marker.
STOP_BYTE, 8'h7E, frame stop marker.
MAX_LEN, 1024, maximum payload bytes per frame, range 1..65535.

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
rxbyte_tvalid  in  1  raw byte valid
rxbyte_tready  out  1  raw byte ready
rxbyte_tdata  in  8  raw byte
rxframe_tvalid  out  1  payload byte valid
rxframe_tready  in  1  payload byte ready
rxframe_tdata  out  8  payload byte
rxframe_tlast  out  1  last byte of frame
rxframe_tuser  out  1  frame aborted; valid only with tlast
err_count  out  16  saturating count of protocol errors
in_frame  out  1  high while state is not HUNT

Behaviour:
- Interface: one clock aclk; reset areset is synchronous, active-high.
- Reset: state=HUNT, hold empty, rxframe_tvalid=0, tdata/tlast/tuser=0, err_count=0, in_frame=0. Reset mid-frame discards the partial frame. No tlast is emitted for it.
- Storage: one hold register holding the newest payload byte, plus one output register (rxframe_*).
- rxbyte_tready = !rxframe_tvalid || rxframe_tready. Every accepted byte is processed in its accept cycle and may load the output register.
- Output register: loads on the accept edge; holds steady while tvalid && !tready (AXI rules). Payload byte N appears on the output 1 cycle after byte N+1 or the STOP is accepted.
- FSM states: HUNT, DATA, ESC.
  - HUNT: START -> DATA with len=0. All other bytes are dropped silently.
  - DATA:
    - START -> abort (see below), then DATA with len=0 (resync to the new frame).
    - STOP with hold full -> emit hold with tlast=1, tuser=0, then HUNT.
    - STOP with hold empty (empty frame) -> HUNT, nothing emitted, not an error.
    - ESCAPE -> ESC.
    - Any other byte -> payload.
  - ESC:
    - START, STOP or ESCAPE -> payload (literal byte), then DATA.
    - Any other byte -> abort, then HUNT.
- Payload action:
  - If len==MAX_LEN -> abort, then HUNT; the byte is dropped.
  - Otherwise: if hold is full, emit hold with tlast=0; hold<=byte; len++.
- Abort action:
  - If hold is full, emit hold with tlast=1, tuser=1.
  - If hold is empty, nothing is emitted.
  - Hold is cleared; err_count increments and saturates at 16'hFFFF.
- len is 16 bits wide and never wraps (bounded by MAX_LEN).
- in_frame is registered: high in DATA and ESC.

Decomposition:
- Shared package framing_pkg holds ESCAPE_BYTE, START_BYTE and STOP_BYTE defaults, plus typedef enum logic [1:0] {HUNT, DATA, ESC} deframe_state_t.
- No sub-module is needed: the output register is a plain registered AXI stage, kept inline.

Test Plan:
- Normal frame: 7D 01 02 03 7E -> outputs 01/tlast0, 02/tlast0, 03/tlast1, tuser0; err_count=0.
- Escapes plus backpressure: 7D 7F 7D 7F 7F 7F 7E 7E with rxframe_tready toggling 1010 -> outputs 7D, 7F, 7E/tlast1. The stream is held stable while stalled, and rxbyte_tready=0 whenever the output is full and stalled.
- Bad escape: 7D AA 7F 41 BB 7E -> AA/tlast1/tuser1; err_count=1; BB and 7E dropped in HUNT.
- START mid-frame plus empty frame: 7D 11 7D 22 7E 7D 7E -> 11/tlast1/tuser1, then 22/tlast1/tuser0; the empty frame produces no output; err_count=1.
- Over-length with MAX_LEN=2: 7D 01 02 03 7E -> 01/tlast0, 02/tlast1/tuser1; err_count=1; 7E ignored. Back-to-back frames follow without idle cycles.
- Reset mid-frame: 7D 01 02, then areset for 1 cycle, then 7D 05 7E -> only 05/tlast1 seen after reset; err_count=0; in_frame=0 right after reset.
